// File: rtl/tk1_cpu_mon_multi.sv
//------------------------------------------------------------------------------
// tk1_cpu_mon_multi
// Multi-window CPU execution/write monitor for the tk1 core.
//   - NUM_WIN programmable address windows, each with deny-execute and
//     deny-write policy, active once the block is armed.
//   - Fixed firmware-RAM execute guard [FW_FIRST, FW_LAST], always active.
//   - Sticky violation capture: first address, hit mask, saturating count.
//   - Lifecycle OPEN -> ARMED <-> TRIPPED; only reset returns to OPEN.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   fw_app_mode           1 = application mode (blocks status clear)
//   cpu_addr/valid/instr/write  observed CPU bus request
//   force_trap            trap request to the CPU (combinational)
//   violation             sticky violation flag
//   cs/we/address/write_data/read_data/ready  8-bit-address register bus
//------------------------------------------------------------------------------
module tk1_cpu_mon_multi #(
  parameter int unsigned NUM_WIN   = 4,
  parameter int unsigned CTR_WIDTH = 16,
  parameter logic [31:0] FW_FIRST  = 32'hd0000000,
  parameter logic [31:0] FW_LAST   = 32'hd00007ff
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        fw_app_mode,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_valid,
  input  logic        cpu_instr,
  input  logic        cpu_write,
  output logic        force_trap,
  output logic        violation,
  input  logic        cs,
  input  logic        we,
  input  logic [7:0]  address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready
);

  localparam int unsigned MW = NUM_WIN + 1;
  localparam logic [CTR_WIDTH-1:0] CTR_ONE = CTR_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_OPEN,
    ST_ARMED,
    ST_TRIPPED
  } state_t;

  state_t               state;
  logic [31:0]          win_first [NUM_WIN];
  logic [31:0]          win_last  [NUM_WIN];
  logic [2:0]           win_mode  [NUM_WIN];
  logic                 halt;
  logic [31:0]          viol_addr;
  logic [MW-1:0]        viol_mask;
  logic [CTR_WIDTH-1:0] counter;
  logic                 hit_q;

  logic [MW-1:0]        hit_vec;
  logic                 hit;
  logic                 evt;
  logic                 armed;

  // Register decode
  logic       bus_wr;
  logic       ctrl_wr;
  logic       status_clr;
  logic       win_rng;
  logic       mode_rng;
  logic [2:0] win_idx;
  logic [2:0] mode_idx;

  assign bus_wr     = cs & we;
  assign ctrl_wr    = bus_wr && (address == 8'h00);
  assign status_clr = bus_wr && (address == 8'h01) && write_data[0] && !fw_app_mode;
  assign win_rng    = (address[7:4] == 4'h1);
  assign win_idx    = address[3:1];
  assign mode_rng   = (address[7:3] == 5'b00100);
  assign mode_idx   = address[2:0];
  assign armed      = (state != ST_OPEN);

  // Hit detection: bit NUM_WIN is the firmware guard, lower bits the windows.
  // A window with first > last can never satisfy both compares.
  always_comb begin
    hit_vec = '0;
    for (int unsigned i = 0; i < NUM_WIN; i++) begin
      if (armed && cpu_valid && win_mode[i][0] &&
          (cpu_addr >= win_first[i]) && (cpu_addr <= win_last[i]) &&
          ((cpu_instr && win_mode[i][1]) || (cpu_write && win_mode[i][2])))
        hit_vec[i] = 1'b1;
    end
    hit_vec[NUM_WIN] = cpu_valid && cpu_instr &&
                       (cpu_addr >= FW_FIRST) && (cpu_addr <= FW_LAST);
  end

  assign hit        = |hit_vec;
  assign evt        = hit & ~hit_q;
  assign force_trap = hit | (halt & violation);
  assign ready      = cs;

  always_comb begin
    read_data = '0;
    if (cs && !we) begin
      unique case (address)
        8'h00: read_data[1:0] = {halt, armed};
        8'h01: begin
          read_data[0]      = violation;
          read_data[1]      = armed;
          read_data[8 +: MW] = viol_mask;
        end
        8'h02: read_data = viol_addr;
        8'h03: read_data[CTR_WIDTH-1:0] = counter;
        default: begin
          for (int unsigned i = 0; i < NUM_WIN; i++) begin
            if (win_rng && win_idx == 3'(i))
              read_data = address[0] ? win_last[i] : win_first[i];
            if (mode_rng && mode_idx == 3'(i))
              read_data[2:0] = win_mode[i];
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_OPEN;
      for (int unsigned i = 0; i < NUM_WIN; i++) begin
        win_first[i] <= '0;
        win_last[i]  <= '0;
        win_mode[i]  <= '0;
      end
      halt      <= 1'b0;
      violation <= 1'b0;
      viol_addr <= '0;
      viol_mask <= '0;
      counter   <= '0;
      hit_q     <= 1'b0;
    end else begin
      hit_q <= hit;

      if (state == ST_OPEN) begin
        for (int unsigned i = 0; i < NUM_WIN; i++) begin
          if (bus_wr && win_rng && win_idx == 3'(i)) begin
            if (address[0]) win_last[i]  <= write_data;
            else            win_first[i] <= write_data;
          end
          if (bus_wr && mode_rng && mode_idx == 3'(i))
            win_mode[i] <= write_data[2:0];
        end
        if (ctrl_wr) begin
          if (write_data[1]) halt  <= 1'b1;
          if (write_data[0]) state <= ST_ARMED;
        end
      end

      // A new event overrides a simultaneous clear: the clear wipes the old
      // record and the event is captured as the first one of a fresh record.
      if (evt) begin
        if (status_clr)            counter <= CTR_ONE;
        else if (counter != '1)    counter <= counter + CTR_ONE;
        if (!violation || status_clr) begin
          viol_addr <= cpu_addr;
          viol_mask <= hit_vec;
        end
        violation <= 1'b1;
        if (state != ST_OPEN) state <= ST_TRIPPED;
      end else if (status_clr) begin
        violation <= 1'b0;
        viol_addr <= '0;
        viol_mask <= '0;
        counter   <= '0;
        if (state == ST_TRIPPED) state <= ST_ARMED;
      end
    end
  end

endmodule

// File: doc/tk1_cpu_mon_multi.md
Name: tk1_cpu_mon_multi

Overview:
Parametrised successor to the single-window CPU execution monitor in the tk1 core. It provides NUM_WIN independent address windows, each with separate deny-execute and deny-write policy. It also adds a fixed firmware-RAM execute guard, sticky violation capture (address, window mask, saturating count) and a config-lock/arm state machine. It sits beside tk1 on the same 8-bit-address register bus, and its force_trap output is ORed into the CPU trap input at top level.

Parameters:
NUM_WIN, 4, number of programmable windows (1..8)
CTR_WIDTH, 16, width of violation counter (1..32)
FW_FIRST, 32'hd0000000, first address of the always-guarded firmware RAM
FW_LAST, 32'hd00007ff, last address of the always-guarded firmware RAM

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
fw_app_mode  in  1  1 = application mode; gates privileged writes
cpu_addr  in  32  CPU bus address
cpu_valid  in  1  CPU bus request valid
cpu_instr  in  1  request is an instruction fetch
cpu_write  in  1  request is a data write
force_trap  out  1  trap request to CPU
violation  out  1  sticky violation flag
cs  in  1  register select
we  in  1  register write
address  in  8  register address
write_data  in  32  register write data
read_data  out  32  register read data
ready  out  1  register access done

Behaviour:
- Reset (async, reset_n=0): state OPEN; all windows first=0, last=0, mode=0; violation=0; viol_addr=0; viol_mask=0; counter=0; halt bit=0. Outputs: force_trap=0 (no cpu_valid), violation=0, ready=0, read_data=0.
- Register map:
  - 0x00 CTRL: bit0 ARM, set-only; bit1 HALT, set-only, writable only in OPEN.
  - 0x01 STATUS: bit0 violation, bit1 armed, bits[8+NUM_WIN:8] viol_mask, where bit 8+NUM_WIN is the FW guard.
  - 0x02 VIOL_ADDR.
  - 0x03 VIOL_CNT, zero-extended.
  - 0x10+2i WIN_FIRST[i]; 0x11+2i WIN_LAST[i].
  - 0x20+i WIN_MODE[i]: bit0 enable, bit1 deny_exec, bit2 deny_write.
  - Unmapped addresses and windows i>=NUM_WIN read 0; writes to them are ignored.
- Bus timing: ready=cs in the same cycle; read_data is combinational and 0 when cs=0 or we=1. Writes take effect on the next clk edge.
- States:
  - OPEN: window registers writable.
  - ARMED: window and CTRL writes ignored; windows active.
  - TRIPPED: as ARMED, plus violation latched.
  - Transitions: OPEN->ARMED on a CTRL write with bit0=1. ARMED->TRIPPED on a violation. TRIPPED->ARMED on a STATUS write with bit0=1 and fw_app_mode=0. There is no path back to OPEN except reset.
- Window hit i: cpu_valid & enable_i & (first_i <= cpu_addr <= last_i), unsigned compare, and (cpu_instr&deny_exec_i | cpu_write&deny_write_i). A window with first>last never hits.
- FW hit: cpu_valid & cpu_instr & FW_FIRST <= cpu_addr <= FW_LAST. This is active in every state, including OPEN.
- hit = FW hit | (state!=OPEN & any window hit).
- force_trap = hit (combinational, same cycle) | (HALT & violation). When HALT is set, force_trap stays 1 after the first violation until the status is cleared.
- Event = hit & !hit_q, where hit_q is hit registered. A request held for multiple cycles counts once.
- On an event:
  - counter increments, saturating at 2^CTR_WIDTH-1.
  - If violation=0: capture viol_addr=cpu_addr and viol_mask=hit vector, then set violation=1.
  - Later events leave viol_addr and viol_mask unchanged.
- STATUS clear (write bit0=1, fw_app_mode=0) zeroes violation, viol_addr, viol_mask and counter. The write is ignored when fw_app_mode=1.
- Clear and event in the same cycle: the event wins. Result is violation=1, counter=1, and address/mask from the new event.
- Reset mid-violation: all state returns to reset values immediately and force_trap drops combinationally with HALT.

Test Plan:
- FW guard: in OPEN, fetch 0xd0000010 -> force_trap=1 that cycle, VIOL_ADDR=0xd0000010, mask bit 8+NUM_WIN set, count=1. A data write to the same address produces no trap.
- Window deny_write: win0=[0x4000_0000,0x4000_00ff], mode=0b101, ARM. Write 0x400000ff -> trap, mask bit8. Write 0x40000100 and fetch 0x40000010 -> no trap.
- Lock: after ARM, write WIN_FIRST[0]=0, then read it -> original value. A second CTRL write of bit0=0 leaves armed=1.
- Saturation: CTR_WIDTH=2, five separate violating pulses -> VIOL_CNT=3. A request held valid for 4 cycles counts 1.
- Clear gating: with fw_app_mode=1, a STATUS clear leaves violation=1. With fw_app_mode=0, the same clear gives violation=0 and count=0. Clear plus a simultaneous hit -> violation=1, count=1.
- HALT plus async reset: HALT and ARM set, then a violation -> force_trap stays high with cpu_valid=0. Asserting reset_n=0 mid-cycle -> force_trap=0, STATUS=0 without waiting for a clk edge.
